// File: rtl/horner_sequencer.sv
// Control sequencer for the ADC correction polynomial: drives one shared multiplier
// and one shared adder through centring, scaling and a Horner loop over c[ORDER..0].
module horner_sequencer #(
    parameter int unsigned ORDER   = 10,
    parameter int unsigned SEL_W   = 4,
    parameter int unsigned TIMEOUT = 64
) (
    input  logic             sys_clk_i,
    input  logic             reset_i,
    input  logic             srdyi,
    output logic             busy_o,
    output logic             x_load_o,
    output logic             add_go_o,
    output logic             add_sel_o,
    input  logic             add_done_i,
    output logic             mul_go_o,
    output logic             mul_sel_o,
    input  logic             mul_done_i,
    output logic [SEL_W-1:0] coeff_sel_o,
    output logic             xn_load_o,
    output logic             acc_init_o,
    output logic             acc_load_o,
    output logic             srdyo,
    output logic             overrun_o,
    output logic             err_o
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CENTER,
        S_SCALE,
        S_MUL,
        S_ADD,
        S_DONE
    } state_e;

    state_e           state_q, state_d;
    logic [SEL_W-1:0] k_q, k_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             busy_q, busy_d;
    logic             add_go_q, add_go_d;
    logic             add_sel_q, add_sel_d;
    logic             mul_go_q, mul_go_d;
    logic             mul_sel_q, mul_sel_d;
    logic             srdyo_q, srdyo_d;
    logic             overrun_q, overrun_d;
    logic             err_q, err_d;
    logic             in_op;
    logic             armed;
    logic             entering;

    // Load strobes are combinational: the datapath must capture a unit result in its done cycle.
    always_comb begin
        state_d    = state_q;
        k_d        = k_q;
        cnt_d      = '0;
        err_d      = 1'b0;
        x_load_o   = 1'b0;
        xn_load_o  = 1'b0;
        acc_init_o = 1'b0;
        acc_load_o = 1'b0;
        in_op      = (state_q inside {S_CENTER, S_SCALE, S_MUL, S_ADD});
        // cnt_q is zero only in the go cycle, so a done there is ignored
        armed      = (cnt_q != '0);

        case (state_q)
            S_IDLE: begin
                if (srdyi) begin
                    x_load_o = 1'b1;
                    k_d      = SEL_W'(ORDER);
                    state_d  = S_CENTER;
                end
            end
            S_CENTER: begin
                if (add_done_i && armed) begin
                    state_d = S_SCALE;
                end
            end
            S_SCALE: begin
                if (mul_done_i && armed) begin
                    xn_load_o  = 1'b1;
                    acc_init_o = 1'b1;
                    if (ORDER == 0) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = SEL_W'(ORDER - 1);
                        state_d = S_MUL;
                    end
                end
            end
            S_MUL: begin
                if (mul_done_i && armed) begin
                    state_d = S_ADD;
                end
            end
            S_ADD: begin
                if (add_done_i && armed) begin
                    acc_load_o = 1'b1;
                    if (k_q == '0) begin
                        state_d = S_DONE;
                    end else begin
                        k_d     = k_q - SEL_W'(1);
                        state_d = S_MUL;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Still waiting on a unit: count, or abort once the budget is spent.
        if (in_op && (state_d == state_q)) begin
            if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                state_d = S_IDLE;
                k_d     = '0;
                err_d   = 1'b1;
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end

        if (reset_i) begin
            x_load_o   = 1'b0;
            xn_load_o  = 1'b0;
            acc_init_o = 1'b0;
            acc_load_o = 1'b0;
        end

        entering  = (state_d != state_q);
        busy_d    = (state_d != S_IDLE);
        add_go_d  = entering && ((state_d == S_CENTER) || (state_d == S_ADD));
        mul_go_d  = entering && ((state_d == S_SCALE) || (state_d == S_MUL));
        add_sel_d = (state_d == S_ADD);
        mul_sel_d = (state_d == S_MUL);
        srdyo_d   = (state_d == S_DONE);
        overrun_d = srdyi && (state_q != S_IDLE);
    end

    always_ff @(posedge sys_clk_i) begin
        if (reset_i) begin
            state_q   <= S_IDLE;
            k_q       <= '0;
            cnt_q     <= '0;
            busy_q    <= 1'b0;
            add_go_q  <= 1'b0;
            add_sel_q <= 1'b0;
            mul_go_q  <= 1'b0;
            mul_sel_q <= 1'b0;
            srdyo_q   <= 1'b0;
            overrun_q <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            k_q       <= k_d;
            cnt_q     <= cnt_d;
            busy_q    <= busy_d;
            add_go_q  <= add_go_d;
            add_sel_q <= add_sel_d;
            mul_go_q  <= mul_go_d;
            mul_sel_q <= mul_sel_d;
            srdyo_q   <= srdyo_d;
            overrun_q <= overrun_d;
            err_q     <= err_d;
        end
    end

    assign busy_o      = busy_q;
    assign add_go_o    = add_go_q;
    assign add_sel_o   = add_sel_q;
    assign mul_go_o    = mul_go_q;
    assign mul_sel_o   = mul_sel_q;
    assign coeff_sel_o = k_q;
    assign srdyo       = srdyo_q;
    assign overrun_o   = overrun_q;
    assign err_o       = err_q;

endmodule

// File: tb/tb_horner_sequencer.sv
// Self-checking bench for horner_sequencer: behaves as the datapath and both units,
// and compares the final accumulator against a direct polynomial evaluation.
module tb_horner_sequencer;

    localparam int unsigned ORDER   = 10;
    localparam int unsigned SEL_W   = 4;
    localparam int unsigned TIMEOUT = 64;

    logic             clk = 1'b0;
    logic             reset_i;
    logic             srdyi;
    logic             busy_o;
    logic             x_load_o;
    logic             add_go_o;
    logic             add_sel_o;
    logic             add_done_i;
    logic             mul_go_o;
    logic             mul_sel_o;
    logic             mul_done_i;
    logic [SEL_W-1:0] coeff_sel_o;
    logic             xn_load_o;
    logic             acc_init_o;
    logic             acc_load_o;
    logic             srdyo;
    logic             overrun_o;
    logic             err_o;

    horner_sequencer #(.ORDER(ORDER), .SEL_W(SEL_W), .TIMEOUT(TIMEOUT)) dut (
        .sys_clk_i  (clk),
        .reset_i    (reset_i),
        .srdyi      (srdyi),
        .busy_o     (busy_o),
        .x_load_o   (x_load_o),
        .add_go_o   (add_go_o),
        .add_sel_o  (add_sel_o),
        .add_done_i (add_done_i),
        .mul_go_o   (mul_go_o),
        .mul_sel_o  (mul_sel_o),
        .mul_done_i (mul_done_i),
        .coeff_sel_o(coeff_sel_o),
        .xn_load_o  (xn_load_o),
        .acc_init_o (acc_init_o),
        .acc_load_o (acc_load_o),
        .srdyo      (srdyo),
        .overrun_o  (overrun_o),
        .err_o      (err_o)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // Datapath and unit model
    logic [31:0] coef [ORDER+1];
    logic [31:0] x_val, negmean, invstd;
    logic [31:0] x_r, acc_r, xn_r, add_out, mul_out, add_pend, mul_pend, acc_final;
    int add_due = -1;
    int mul_due = -1;
    int la = 1;
    int lm = 1;
    int cyc = 0;
    int mul_drop = 0;

    int n_add_go, n_mul_go, n_acc_load, n_acc_init, n_xload, n_srdyo, n_errp;
    int srdyo_cyc, err_cyc, drop_go_cyc, init_sel;
    int ovr_q[$];
    int sel_q[$];
    bit srdyi_req = 0;
    bit rst_req   = 0;
    bit stray_req = 0;

    function automatic logic [31:0] outvec();
        return 32'({busy_o, x_load_o, add_go_o, add_sel_o, mul_go_o, mul_sel_o, coeff_sel_o,
                    xn_load_o, acc_init_o, acc_load_o, srdyo, overrun_o, err_o});
    endfunction

    function automatic logic [31:0] poly_ref(input logic [31:0] x, input logic [31:0] nm,
                                             input logic [31:0] is);
        logic [31:0] xn, sum, p;
        xn  = (x + nm) * is;
        sum = 0;
        p   = 1;
        for (int k = 0; k <= int'(ORDER); k++) begin
            sum = sum + coef[k] * p;
            p   = p * xn;
        end
        return sum;
    endfunction

    function automatic int exp_lat(input int a, input int m);
        return 1 + (a + 1) + (m + 1) + int'(ORDER) * (a + m + 2);
    endfunction

    task automatic clear_counts();
        n_add_go = 0; n_mul_go = 0; n_acc_load = 0; n_acc_init = 0;
        n_xload = 0; n_srdyo = 0; n_errp = 0;
        srdyo_cyc = -1; err_cyc = -1; drop_go_cyc = -1; init_sel = -1;
        ovr_q.delete();
        sel_q.delete();
    endtask

    // One clock: drive inputs after the edge, observe outputs at the falling edge.
    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
        srdyi      = srdyi_req;
        reset_i    = rst_req;
        add_done_i = (add_due == cyc) || stray_req;
        mul_done_i = (mul_due == cyc);
        srdyi_req  = 0;
        rst_req    = 0;
        stray_req  = 0;
        @(negedge clk);
        if (add_done_i) add_out = add_pend;
        if (mul_done_i) mul_out = mul_pend;
        if (x_load_o) begin x_r = x_val; n_xload++; end
        if (xn_load_o) xn_r = mul_out;
        if (acc_init_o) begin acc_r = coef[ORDER]; n_acc_init++; init_sel = int'(coeff_sel_o); end
        if (acc_load_o) begin acc_r = add_out; n_acc_load++; end
        if (add_go_o) begin
            n_add_go++;
            add_pend = add_sel_o ? (mul_out + coef[coeff_sel_o]) : (x_r + negmean);
            if (add_sel_o) sel_q.push_back(int'(coeff_sel_o));
            add_due = cyc + la;
        end
        if (mul_go_o) begin
            n_mul_go++;
            mul_pend = mul_sel_o ? (acc_r * xn_r) : (add_out * invstd);
            if (n_mul_go == mul_drop) begin
                mul_due     = -1;
                drop_go_cyc = cyc;
            end else begin
                mul_due = cyc + lm;
            end
        end
        if (srdyo) begin n_srdyo++; srdyo_cyc = cyc; acc_final = acc_r; end
        if (err_o) begin n_errp++; err_cyc = cyc; end
        if (overrun_o) ovr_q.push_back(cyc);
    endtask

    task automatic run_sample(input int a, input int m, input bit ovr, input int rst_at,
                              input int stray_at, output int start);
        int  rel;
        bit  ended;
        la      = a;
        lm      = m;
        x_val   = $urandom;
        negmean = $urandom;
        invstd  = $urandom;
        clear_counts();
        srdyi_req = 1;
        tick();
        start = cyc;
        ended = 0;
        for (int i = 0; i < 600 && !ended; i++) begin
            rel = cyc + 1 - start;
            if (ovr && (rel == 10 || rel == 44)) srdyi_req = 1;
            if (rel == rst_at) rst_req = 1;
            if (rel == stray_at) stray_req = 1;
            tick();
            if (rst_at > 0 && (rel == rst_at + 1 || rel == rst_at + 2))
                check("reset_mid_outputs", outvec(), 0);
            if (n_srdyo > 0 || n_errp > 0 || (rst_at > 0 && rel >= rst_at + 8)) ended = 1;
        end
        check("run_bound", 64'(ended), 1);
        repeat (8) tick();
    endtask

    task automatic check_normal(input string tag, input int start, input int a, input int m);
        check({tag, "_latency"}, 64'(srdyo_cyc - start), 64'(exp_lat(a, m)));
        check({tag, "_srdyo_cnt"}, 64'(n_srdyo), 1);
        check({tag, "_add_go"}, 64'(n_add_go), 64'(ORDER + 1));
        check({tag, "_mul_go"}, 64'(n_mul_go), 64'(ORDER + 1));
        check({tag, "_acc_load"}, 64'(n_acc_load), 64'(ORDER));
        check({tag, "_acc_init"}, 64'(n_acc_init), 1);
        check({tag, "_acc_value"}, 64'(acc_final), 64'(poly_ref(x_val, negmean, invstd)));
        check({tag, "_err"}, 64'(n_errp), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int st;
        int a, m;
        reset_i    = 1'b1;
        srdyi      = 1'b0;
        add_done_i = 1'b0;
        mul_done_i = 1'b0;
        for (int k = 0; k <= int'(ORDER); k++) coef[k] = $urandom;
        x_r = 0; acc_r = 0; xn_r = 0; add_out = 0; mul_out = 0; add_pend = 0; mul_pend = 0;
        acc_final = 0;
        clear_counts();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_outputs", outvec(), 0);
        repeat (2) tick();

        // Unit latency 1, coefficient order
        run_sample(1, 1, 0, 0, 0, st);
        check_normal("l1", st, 1, 1);
        check("l1_latency45", 64'(srdyo_cyc - st), 45);
        check("init_coeff_sel", 64'(init_sel), 64'(ORDER));
        check("sel_count", 64'(sel_q.size()), 64'(ORDER));
        for (int i = 0; i < sel_q.size(); i++)
            check("add_coeff_sel", 64'(sel_q[i]), 64'(int'(ORDER) - 1 - i));

        // Unequal unit latencies
        run_sample(3, 5, 0, 0, 0, st);
        check_normal("l35", st, 3, 5);
        check("l35_latency111", 64'(srdyo_cyc - st), 111);

        // Overrun while busy
        run_sample(1, 1, 1, 0, 0, st);
        check_normal("ovr", st, 1, 1);
        check("ovr_count", 64'(ovr_q.size()), 2);
        if (ovr_q.size() == 2) begin
            check("ovr_first", 64'(ovr_q[0] - st), 11);
            check("ovr_second", 64'(ovr_q[1] - st), 45);
        end
        check("ovr_xload", 64'(n_xload), 1);
        run_sample(1, 1, 0, 0, 0, st);
        check_normal("after_ovr", st, 1, 1);

        // Multiplier never answers in the third MUL
        mul_drop = 4;
        run_sample(1, 1, 0, 0, 0, st);
        mul_drop = 0;
        check("to_err_cnt", 64'(n_errp), 1);
        check("to_err_delay", 64'(err_cyc - drop_go_cyc), 64'(TIMEOUT));
        check("to_srdyo", 64'(n_srdyo), 0);
        check("to_busy", 64'(busy_o), 0);
        run_sample(2, 1, 0, 0, 0, st);
        check_normal("after_to", st, 2, 1);

        // Reset mid-sequence with a stray adder done afterwards
        run_sample(1, 1, 0, 20, 22, st);
        check("rst_srdyo", 64'(n_srdyo), 0);
        check("rst_busy", 64'(busy_o), 0);
        run_sample(1, 1, 0, 0, 0, st);
        check_normal("after_rst", st, 1, 1);

        // Random unit latencies and operands
        for (int n = 0; n < 6; n++) begin
            a = int'($urandom_range(1, 5));
            m = int'($urandom_range(1, 5));
            run_sample(a, m, 0, 0, 0, st);
            check_normal("rand", st, a, m);
        end

        $display("Result: errors=%0d of %0d checks", n_fail, n_chk);
        $finish;
    end

endmodule
